// File: rtl/captura_entrada_pkg.sv
// Shared definitions for the input-capture stage: default sizes and FSM state encoding.
package captura_entrada_pkg;

  localparam int DATA_W_DEF          = 18;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF           = 20;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    DEB_PRESS = 3'd2,
    CAPTURE   = 3'd3,
    VALID     = 3'd4,
    WAIT_REL  = 3'd5
  } estado_t;

  function automatic logic is_waiting(estado_t s);
    return (s == ARMED) || (s == DEB_PRESS);
  endfunction

endpackage

// File: rtl/captura_entrada_if.sv
// Request/ack handshake between the control unit/processor and the capture stage.
interface captura_entrada_if
  import captura_entrada_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              in;
  logic              ack;
  logic              sinal;
  logic [DATA_W-1:0] valor;
  logic              esperando;

  modport master (output in, output ack, input sinal, input valor, input esperando);
  modport slave  (input in, input ack, output sinal, output valor, output esperando);

endinterface

// File: rtl/captura_entrada_debounce_botao.sv
// Two-flop synchronizer for the raw ENTER button plus a saturating stability counter.
module captura_entrada_debounce_botao
  import captura_entrada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic enter,
  output logic enter_s,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Counter restarts on the same edge enter_s takes a new value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync <= 2'b11;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], enter};
      if (sync[0] != sync[1]) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign enter_s = sync[1];
  assign stable  = (cnt == CNT_MAX);

endmodule

// File: rtl/captura_entrada.sv
// Input-capture stage: debounced ENTER latches the switch word and offers it
// to the processor through a valid/ack handshake while input is requested.
module captura_entrada
  import captura_entrada_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enter,
  input  logic [DATA_W-1:0] entrada,
  captura_entrada_if.slave  bus
);

  logic              enter_s;
  logic              stable;
  logic              enter_q;
  logic              fell;
  logic [DATA_W-1:0] entrada_m;
  logic [DATA_W-1:0] entrada_s;
  logic [DATA_W-1:0] valor_q;
  estado_t           state;
  estado_t           state_nx;

  captura_entrada_debounce_botao #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce_botao (
    .clock   (clock),
    .reset   (reset),
    .enter   (enter),
    .enter_s (enter_s),
    .stable  (stable)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      entrada_m <= '0;
      entrada_s <= '0;
    end else begin
      entrada_m <= entrada;
      entrada_s <= entrada_m;
    end
  end

  // A press counts only as a high-to-low transition, so a button already
  // held when the request arrives keeps the FSM parked in ARMED.
  always_ff @(posedge clock) begin
    if (!reset) begin
      enter_q <= 1'b1;
    end else begin
      enter_q <= enter_s;
    end
  end

  assign fell = enter_q && !enter_s;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The debounce counter was already cleared by the falling transition,
  // which is what keeps press-to-valid latency at DEBOUNCE_CYCLES+3 edges.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.in) state_nx = ARMED;
      end
      ARMED: begin
        if (!bus.in)   state_nx = IDLE;
        else if (fell) state_nx = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!bus.in)      state_nx = IDLE;
        else if (enter_s) state_nx = ARMED;
        else if (stable)  state_nx = CAPTURE;
      end
      CAPTURE: begin
        state_nx = VALID;
      end
      VALID: begin
        if (bus.ack) state_nx = WAIT_REL;
      end
      WAIT_REL: begin
        if (enter_s && stable) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valor_q <= '0;
    end else if (state == CAPTURE) begin
      valor_q <= entrada_s;
    end
  end

  assign bus.sinal     = (state == VALID);
  assign bus.valor     = valor_q;
  assign bus.esperando = is_waiting(state);

endmodule

// File: tb/tb_captura_entrada.sv
// Bench for captura_entrada: directed scenarios plus a random soak, all checked
// every cycle against a window-based behavioural model of the capture stage.
module tb_captura_entrada;

  localparam int DW = 18;
  localparam int DB = 4;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enter;
  logic [DW-1:0] entrada;

  captura_entrada_if #(.DATA_W(DW)) bus ();

  captura_entrada #(
    .DATA_W          (DW),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (CW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .enter   (enter),
    .entrada (entrada),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_n = 0;
  int   rises = 0;
  int   rise_edge = -1;
  int   e0 = 0;
  logic sinal_prev = 1'b0;

  // Model: phase of the handshake, captured word, and histories of the
  // synchronized button (newest first) and the switch word pipeline.
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DEB   = 2;
  localparam int M_CAP   = 3;
  localparam int M_VALID = 4;
  localparam int M_WAIT  = 5;

  int            mode;
  logic [DW-1:0] m_valor;
  logic [DW-1:0] m_ent0;
  logic [DW-1:0] m_ent1;
  bit            m_s0;
  bit            es_hist[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Stable: the synchronized button held one value over the last DB edges.
  function automatic bit window_stable();
    if (es_hist.size() < DB) return 1'b0;
    for (int i = 1; i < DB; i++)
      if (es_hist[i] != es_hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mode    = M_IDLE;
    m_valor = '0;
    m_ent0  = '0;
    m_ent1  = '0;
    m_s0    = 1'b1;
    es_hist.delete();
    es_hist.push_front(1'b1);
  endtask

  task automatic model_edge();
    bit es;
    bit es_prev;
    bit stab;
    if (!reset) begin
      model_reset();
      return;
    end
    es      = es_hist[0];
    es_prev = (es_hist.size() > 1) ? es_hist[1] : 1'b1;
    stab    = window_stable();
    case (mode)
      M_IDLE:  if (bus.in) mode = M_ARMED;
      M_ARMED: begin
        if (!bus.in) mode = M_IDLE;
        else if (!es && es_prev) mode = M_DEB;
      end
      M_DEB: begin
        if (!bus.in) mode = M_IDLE;
        else if (es) mode = M_ARMED;
        else if (stab) mode = M_CAP;
      end
      M_CAP: begin
        m_valor = m_ent1;
        mode    = M_VALID;
      end
      M_VALID: if (bus.ack) mode = M_WAIT;
      M_WAIT:  if (es && stab) mode = M_IDLE;
      default: mode = M_IDLE;
    endcase
    es_hist.push_front(m_s0);
    if (es_hist.size() > DB + 1) void'(es_hist.pop_back());
    m_s0   = enter;
    m_ent1 = m_ent0;
    m_ent0 = entrada;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    edge_n++;
    @(negedge clock);
    chk("sinal", 32'(bus.sinal), 32'(mode == M_VALID));
    chk("valor", 32'(bus.valor), 32'(m_valor));
    chk("esperando", 32'(bus.esperando), 32'(mode == M_ARMED || mode == M_DEB));
    if (bus.sinal === 1'b1 && sinal_prev !== 1'b1) begin
      rises++;
      rise_edge = edge_n;
    end
    sinal_prev = bus.sinal;
  endtask

  task automatic wait_rise(input int max_steps);
    for (int i = 0; i < max_steps; i++) begin
      step();
      if (rise_edge >= 0) break;
    end
  endtask

  task automatic ack_pulse();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    enter   = 1'b0;
    bus.in  = 1'b1;
    bus.ack = 1'b0;
    entrada = 18'h3FFFF;
    model_reset();
    repeat (5) step();
    chk("rst_sinal", 32'(bus.sinal), 32'd0);
    chk("rst_valor", 32'(bus.valor), 32'd0);
    chk("rst_esperando", 32'(bus.esperando), 32'd0);

    reset  = 1'b1;
    enter  = 1'b1;
    bus.in = 1'b0;
    entrada = '0;
    repeat (6) step();

    // clean press: valid on the (DB+3)-th edge counting the first low sample
    entrada = 18'h0002A;
    bus.in  = 1'b1;
    repeat (6) step();
    enter = 1'b0;
    e0 = edge_n + 1;
    rise_edge = -1;
    rises = 0;
    wait_rise(20);
    chk("clean_lat", 32'(rise_edge - e0), 32'(DB + 2));
    chk("clean_valor", 32'(bus.valor), 32'h2A);
    repeat (3) step();
    chk("clean_hold", 32'(bus.sinal), 32'd1);
    ack_pulse();
    chk("clean_ack", 32'(bus.sinal), 32'd0);
    enter = 1'b1;
    repeat (10) step();

    // bounce: short low burst, one high clock, then a steady press
    entrada = DW'($urandom);
    rises = 0;
    enter = 1'b0;
    repeat (2) step();
    enter = 1'b1;
    step();
    enter = 1'b0;
    e0 = edge_n + 1;
    rise_edge = -1;
    wait_rise(20);
    chk("bounce_lat", 32'(rise_edge - e0), 32'(DB + 2));
    chk("bounce_valor", 32'(bus.valor), 32'(entrada));
    repeat (2) step();
    ack_pulse();
    enter = 1'b1;
    repeat (10) step();
    chk("bounce_once", 32'(rises), 32'd1);

    // button held before the request arrives
    bus.in = 1'b0;
    repeat (4) step();
    enter = 1'b0;
    repeat (6) step();
    rises = 0;
    bus.in = 1'b1;
    repeat (20) step();
    chk("held_sinal", 32'(bus.sinal), 32'd0);
    chk("held_esp", 32'(bus.esperando), 32'd1);
    chk("held_none", 32'(rises), 32'd0);
    enter = 1'b1;
    repeat (6) step();
    entrada = DW'($urandom);
    enter = 1'b0;
    rise_edge = -1;
    wait_rise(20);
    chk("held_rise", 32'(rise_edge >= 0), 32'd1);
    chk("held_valor", 32'(bus.valor), 32'(entrada));
    ack_pulse();
    enter = 1'b1;
    repeat (10) step();

    // request withdrawn while debouncing
    rises = 0;
    enter = 1'b0;
    repeat (4) step();
    chk("wd_deb_esp", 32'(bus.esperando), 32'd1);
    bus.in = 1'b0;
    repeat (10) step();
    chk("wd_none", 32'(rises), 32'd0);
    chk("wd_esp_off", 32'(bus.esperando), 32'd0);

    // request withdrawn while the word is valid
    enter = 1'b1;
    bus.in = 1'b1;
    repeat (8) step();
    entrada = 18'h00155;
    enter = 1'b0;
    rise_edge = -1;
    wait_rise(20);
    bus.in = 1'b0;
    repeat (5) step();
    chk("vw_sinal", 32'(bus.sinal), 32'd1);
    chk("vw_valor", 32'(bus.valor), 32'h155);
    ack_pulse();
    chk("vw_ack", 32'(bus.sinal), 32'd0);
    chk("vw_keep", 32'(bus.valor), 32'h155);
    enter = 1'b1;
    repeat (8) step();

    // reset while the word is valid, then a normal capture
    bus.in = 1'b1;
    repeat (4) step();
    entrada = DW'($urandom);
    enter = 1'b0;
    rise_edge = -1;
    wait_rise(20);
    chk("mid_valid", 32'(bus.sinal), 32'd1);
    reset = 1'b0;
    step();
    chk("mid_rst_sinal", 32'(bus.sinal), 32'd0);
    chk("mid_rst_valor", 32'(bus.valor), 32'd0);
    reset = 1'b1;
    enter = 1'b1;
    repeat (6) step();
    entrada = DW'($urandom);
    enter = 1'b0;
    rise_edge = -1;
    wait_rise(20);
    chk("post_rst_valor", 32'(bus.valor), 32'(entrada));
    ack_pulse();
    enter = 1'b1;
    repeat (8) step();

    // random soak
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0)   enter = ~enter;
      if ($urandom_range(0, 30) == 0)  bus.in = ~bus.in;
      if ($urandom_range(0, 20) == 0)  entrada = DW'($urandom);
      bus.ack = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 400) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
